// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// load/store stage. Data accesses win by default. A streak counter forces a
// pending fetch through after MAX_D_STREAK back-to-back data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // load/store requester
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  // fetch requester
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  // memory side
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // hazard unit
  output logic              stall_o
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  logic [STREAK_W-1:0] streak;
  logic                force_i_c;
  logic                take_d_c;

  // Fetch is forced only when it is actually waiting and data has hit its limit
  assign force_i_c = i_req_i && (streak == STREAK_MAX);
  assign take_d_c  = d_req_i && !force_i_c;

  // Stall while a request is up and not being acknowledged; silent in reset
  assign stall_o = rst_i & ((d_req_i & ~d_ack_o) | (i_req_i & ~i_ack_o));

  // Arbitration FSM with registered memory-side and completion outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      d_ack_o     <= 1'b0;
      i_ack_o     <= 1'b0;
      d_rdata_o   <= '0;
      i_rdata_o   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take_d_c) begin
            state       <= GNT_D;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            if (!i_req_i) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + STREAK_W'(1);
            end
          end else if (i_req_i) begin
            state       <= GNT_I;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= '0;
            streak      <= '0;
          end
        end

        GNT_D: begin
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            d_ack_o   <= 1'b1;
            // Stores leave the last load value visible
            if (!mem_we_o) begin
              d_rdata_o <= mem_rdata_i;
            end
          end
        end

        GNT_I: begin
          if (mem_ack_i) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            i_ack_o   <= 1'b1;
            i_rdata_o <= mem_rdata_i;
          end
        end

        RESP: begin
          // Always back to IDLE so the acked requester's stale req is not regranted
          state   <= IDLE;
          d_ack_o <= 1'b0;
          i_ack_o <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and completions are
// queued by the stimulus and popped by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        d_ack_o;
  logic        i_req_i;
  logic [31:0] i_addr_i, i_rdata_o;
  logic        i_ack_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i;
  logic        stall_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  len;   // expected mem_req_o high cycles, 0 = do not check
  } gnt_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  gnt_t        exp_gnt[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_i[$];
  dreq_t       dq[$];
  logic [31:0] iq[$];
  logic [31:0] mem [logic [31:0]];
  int          mem_wait = 0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Memory model: acks after mem_wait idle cycles of mem_req_o
  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        wcnt = 0;
      end else if (mem_req_o && rst_i) begin
        if (wcnt >= mem_wait) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i = 32'hBAD0_BAD0;
          end else begin
            mem_rdata_i = mem_rd(mem_addr_o);
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Load/store requester: keeps req up back-to-back while its queue has work
  initial begin : d_port
    dreq_t r;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (d_req_i && d_ack_o) d_req_i = 1'b0;
      if (!d_req_i && dq.size() > 0 && rst_i) begin
        r = dq.pop_front();
        d_we_i = r.we; d_addr_i = r.addr; d_wdata_i = r.wdata; d_req_i = 1'b1;
      end
    end
  end

  // Fetch requester
  initial begin : i_port
    i_req_i = 1'b0; i_addr_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (i_req_i && i_ack_o) i_req_i = 1'b0;
      if (!i_req_i && iq.size() > 0 && rst_i) begin
        i_addr_i = iq.pop_front();
        i_req_i = 1'b1;
      end
    end
  end

  // Monitor: grants, held-request stability, completions, stall
  gnt_t cur;
  int   cur_len = 0;
  logic prev_req = 1'b0, prev_dack = 1'b0, prev_iack = 1'b0;
  always @(negedge clk_i) begin
    if (mem_req_o && !prev_req) begin
      if (exp_gnt.size() == 0) begin
        fails++; tests++;
        $display("FAIL unexpected_grant: addr %h with no grant queued", mem_addr_o);
        cur = '0;
      end else begin
        cur = exp_gnt.pop_front();
      end
      cur_len = 0;
    end
    if (mem_req_o) begin
      cur_len++;
      check("gnt_we",    {31'h0, mem_we_o}, {31'h0, cur.we});
      check("gnt_addr",  mem_addr_o, cur.addr);
      check("gnt_wdata", mem_wdata_o, cur.wdata);
    end
    if (!mem_req_o && prev_req && cur.len != 8'd0)
      check("gnt_len", 32'(cur_len), 32'(cur.len));
    if (d_ack_o) begin
      if (prev_dack) check("d_ack_width", 32'd2, 32'd1);
      else if (exp_d.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
      else check("d_rdata", d_rdata_o, exp_d.pop_front());
    end
    if (i_ack_o) begin
      if (prev_iack) check("i_ack_width", 32'd2, 32'd1);
      else if (exp_i.size() == 0) check("i_ack_unexpected", 32'd1, 32'd0);
      else check("i_rdata", i_rdata_o, exp_i.pop_front());
    end
    check("stall", {31'h0, stall_o},
          {31'h0, rst_i & ((d_req_i & ~d_ack_o) | (i_req_i & ~i_ack_o))});
    prev_req  = mem_req_o;
    prev_dack = d_ack_o;
    prev_iack = i_ack_o;
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((dq.size() > 0 || iq.size() > 0 || d_req_i || i_req_i || exp_gnt.size() > 0 ||
            exp_d.size() > 0 || exp_i.size() > 0) && n < 400) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 32'd1, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic push_gnt(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [7:0] len);
    gnt_t g;
    g.we = we; g.addr = a; g.wdata = wd; g.len = len;
    exp_gnt.push_back(g);
  endtask

  task automatic push_dreq(input logic we, input logic [31:0] a, input logic [31:0] wd);
    dreq_t r;
    r.we = we; r.addr = a; r.wdata = wd;
    dq.push_back(r);
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    rst_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    mem[32'h10]  = 32'h0050_0093;
    mem[32'h14]  = 32'h00A0_0113;
    mem[32'h40]  = 32'h0000_0013;
    mem[32'h44]  = 32'h0010_0073;
    mem[32'h80]  = 32'h0000_0297;
    mem[32'h100] = 32'h1111_2222;
    mem[32'h104] = 32'h3333_4444;
    for (int k = 0; k < 9; k++) mem[32'h200 + 32'(4*k)] = 32'hC000_0000 + 32'(k);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mem_req", {31'h0, mem_req_o}, 32'd0);
    check("rst_d_ack",   {31'h0, d_ack_o}, 32'd0);
    check("rst_i_ack",   {31'h0, i_ack_o}, 32'd0);
    check("rst_d_rdata", d_rdata_o, 32'd0);
    check("rst_i_rdata", i_rdata_o, 32'd0);
    check("rst_addr",    mem_addr_o, 32'd0);
    @(negedge clk_i) rst_i = 1'b1;

    // Single zero-wait fetch
    mem_wait = 0;
    push_gnt(1'b0, 32'h10, 32'h0, 8'd1);
    exp_i.push_back(32'h0050_0093);
    iq.push_back(32'h10);
    wait_done("fetch");

    // Load, then store with 3 wait states, then load back the stored word
    push_gnt(1'b0, 32'h100, 32'h0, 8'd1);
    exp_d.push_back(32'h1111_2222);
    push_dreq(1'b0, 32'h100, 32'h0);
    wait_done("load");
    mem_wait = 3;
    push_gnt(1'b1, 32'h100, 32'hDEAD_BEEF, 8'd4);
    exp_d.push_back(32'h1111_2222);
    push_dreq(1'b1, 32'h100, 32'hDEAD_BEEF);
    wait_done("store");
    check("store_keeps_rdata", d_rdata_o, 32'h1111_2222);
    mem_wait = 1;
    push_gnt(1'b0, 32'h100, 32'h0, 8'd2);
    exp_d.push_back(32'hDEAD_BEEF);
    push_dreq(1'b0, 32'h100, 32'h0);
    wait_done("load_back");

    // Simultaneous requests: data first, then fetch
    mem_wait = 0;
    push_gnt(1'b0, 32'h104, 32'h0, 8'd1);
    push_gnt(1'b0, 32'h14, 32'h0, 8'd1);
    exp_d.push_back(32'h3333_4444);
    exp_i.push_back(32'h00A0_0113);
    push_dreq(1'b0, 32'h104, 32'h0);
    iq.push_back(32'h14);
    wait_done("simul");

    // Starvation guard: D,D,D,D,I,D,D,D,D,I,D
    for (int k = 0; k < 4; k++) push_gnt(1'b0, 32'h200 + 32'(4*k), 32'h0, 8'd1);
    push_gnt(1'b0, 32'h40, 32'h0, 8'd1);
    for (int k = 4; k < 8; k++) push_gnt(1'b0, 32'h200 + 32'(4*k), 32'h0, 8'd1);
    push_gnt(1'b0, 32'h44, 32'h0, 8'd1);
    push_gnt(1'b0, 32'h220, 32'h0, 8'd1);
    for (int k = 0; k < 9; k++) begin
      exp_d.push_back(32'hC000_0000 + 32'(k));
      push_dreq(1'b0, 32'h200 + 32'(4*k), 32'h0);
    end
    exp_i.push_back(32'h0000_0013);
    exp_i.push_back(32'h0010_0073);
    iq.push_back(32'h40);
    iq.push_back(32'h44);
    wait_done("starve");

    // Reset during an unacknowledged fetch
    mem_wait = 20;
    push_gnt(1'b0, 32'h80, 32'h0, 8'd0);
    iq.push_back(32'h80);
    n = 0;
    while (!mem_req_o && n < 20) begin @(posedge clk_i); #1; n++; end
    check("rst_mid_granted", {31'h0, mem_req_o}, 32'd1);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    check("rst_mid_mem_req", {31'h0, mem_req_o}, 32'd0);
    check("rst_mid_i_ack",   {31'h0, i_ack_o}, 32'd0);
    check("rst_mid_stall",   {31'h0, stall_o}, 32'd0);
    check("rst_mid_i_req_held", {31'h0, i_req_i}, 32'd1);
    mem_wait = 0;
    push_gnt(1'b0, 32'h80, 32'h0, 8'd1);
    exp_i.push_back(32'h0000_0297);
    @(negedge clk_i) rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("regrant_mem_req",  {31'h0, mem_req_o}, 32'd1);
    check("regrant_mem_addr", mem_addr_o, 32'h80);
    wait_done("regrant");

    // Stray memory ack while idle
    @(negedge clk_i);
    mem_rdata_i = 32'hFFFF_FFFF;
    mem_ack_i   = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("stray_mem_req", {31'h0, mem_req_o}, 32'd0);
    check("stray_d_rdata", d_rdata_o, 32'h0);
    check("stray_i_rdata", i_rdata_o, 32'h0000_0297);
    check("stray_stall",   {31'h0, stall_o}, 32'd0);

    check("left_gnt", 32'(exp_gnt.size()), 32'd0);
    check("left_d",   32'(exp_d.size()), 32'd0);
    check("left_i",   32'(exp_i.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the pipelined CPU.
- Arbitrates between the two requesters with MEM-stage priority and a bounded starvation guard for fetch.
- Sequences each access through a request/ack handshake on the memory side.
- Drives a stall to the hazard logic while any access is outstanding.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- MAX_D_STREAK, 4, maximum consecutive data grants issued while a fetch is pending before fetch is forced (range 1..15)

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- d_req_i  input  1  MEM-stage request; held high with d_we_i/d_addr_i/d_wdata_i stable until d_ack_o
- d_we_i  input  1  1 = store, 0 = load
- d_addr_i  input  ADDR_W  data address
- d_wdata_i  input  DATA_W  store data
- d_rdata_o  output  DATA_W  load data, valid when d_ack_o
- d_ack_o  output  1  one-cycle completion pulse for the data request
- i_req_i  input  1  fetch request; held high with i_addr_i stable until i_ack_o
- i_addr_i  input  ADDR_W  fetch address
- i_rdata_o  output  DATA_W  instruction word, valid when i_ack_o
- i_ack_o  output  1  one-cycle completion pulse for the fetch
- mem_req_o  output  1  memory request, held until mem_ack_i
- mem_we_o  output  1  memory write enable (0 for fetches)
- mem_addr_o  output  ADDR_W  memory address
- mem_wdata_o  output  DATA_W  memory write data
- mem_rdata_i  input  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  input  1  memory completion, latency 0..N cycles after mem_req_o rises
- stall_o  output  1  pipeline freeze to the hazard unit

Behaviour:
- Reset (rst_i=0, asynchronous):
  - FSM goes to IDLE; streak counter clears.
  - All outputs are 0, including d_rdata_o/i_rdata_o; mem_req_o drops immediately.
  - An access interrupted by reset is abandoned. After release the requester's still-high req is re-arbitrated from scratch.
- FSM states: IDLE, GNT_D, GNT_I, RESP.
- IDLE:
  - d_req_i only -> GNT_D.
  - i_req_i only -> GNT_I.
  - Both high -> GNT_D, unless streak == MAX_D_STREAK, in which case -> GNT_I.
  - Neither -> stay in IDLE.
- Grant entry latches the chosen requester's address, wdata and we into mem_*_o registers (fetch: we=0, wdata=0).
- Streak counter:
  - Increments on each GNT_D entry taken while i_req_i=1.
  - Clears on any GNT_I entry, and on a GNT_D entry taken while i_req_i=0.
  - Saturates at MAX_D_STREAK.
- GNT_D / GNT_I:
  - mem_req_o=1 with the latched signals stable.
  - On mem_ack_i=1 -> RESP. On that edge, mem_req_o falls and the owner's ack pulse and rdata are registered.
- RESP (exactly one cycle):
  - Owner's ack_o=1.
  - Load or fetch: rdata_o = mem_rdata_i captured at the ack edge.
  - Store: d_rdata_o keeps its previous value.
  - Next state is IDLE unconditionally, so the acked requester's still-high req is never re-granted in RESP.
- rdata_o holds its value until the next completion for that port.
- Minimum latency: req sampled in IDLE at edge 0 -> mem_req_o at cycle 1 -> zero-wait ack at cycle 1 -> ack_o at cycle 2 -> IDLE at cycle 3.
- mem_ack_i outside GNT_D/GNT_I is ignored.
- Requester inputs are not re-sampled during a grant; changes mid-access are a protocol violation and are not checked.
- stall_o = (d_req_i & ~d_ack_o) | (i_req_i & ~i_ack_o), combinational.
- No bus errors or timeouts: a grant waits indefinitely for mem_ack_i.

Test Plan:
- Single fetch: i_req_i=1, i_addr_i=0x0000_0010, mem acks 0 wait cycles with 0x0050_0093 -> mem_req_o high cycle 1 with addr 0x10 and we=0; i_ack_o pulse cycle 2 with i_rdata_o=0x0050_0093; stall_o low from cycle 2.
- Store with wait states: d_req_i=1, d_we_i=1, addr 0x0000_0100, wdata 0xDEAD_BEEF, mem_ack_i after 3 cycles -> mem_req_o held exactly 4 cycles with stable addr/wdata and we=1; d_ack_o single pulse; d_rdata_o unchanged.
- Simultaneous requests: d_req_i and i_req_i both rise at cycle 0 -> data served first; fetch granted in the IDLE following the data RESP; exactly one ack pulse per requester.
- Starvation guard, MAX_D_STREAK=4: i_req_i held high while d_req_i re-requests continuously -> grant order D,D,D,D,I,D,...; streak reads 0 after the I grant.
- Reset mid-access: rst_i low while in GNT_I with mem_ack_i not yet given -> mem_req_o, i_ack_o and stall_o are 0 immediately; after release with i_req_i still high, a fresh grant is issued with mem_req_o at cycle 1.
- Stray ack: mem_ack_i=1 in IDLE with no requests -> no ack_o pulse, no state change, rdata outputs unchanged.
